// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot-time instruction memory loader and fetch access controller
//
// Purpose
//    Holds the core stalled after reset, streams a program image into the
//    instruction memory write port, then hands the memory read port to the
//    IF stage and releases the stall. A later load request stalls the core
//    again and reloads the image in place.
//
// Build option
//    IMEM_LOAD_CHECKSUM_EN : adds the image sum accumulator, the CHECK state
//                            and the ERROR state. When undefined the loader
//                            goes straight from LOAD to RUN, load_checksum is
//                            ignored and load_error is tied low.
//
// Ports
//    clk           clock, all state updates on the rising edge
//    rst_n         synchronous active-low reset
//    load_start    request a load session (BOOT_WAIT, RUN, ERROR)
//    load_len      image length in words, 0..2^(ADDR_WIDTH-2)
//    load_checksum expected mod-2^DATA_WIDTH sum of the image words
//    load_valid    load_data holds a valid word
//    load_data     image word
//    load_ready    loader accepts a word this cycle
//    load_done     one-cycle pulse on successful completion
//    load_error    checksum mismatch, held until the next load_start
//    core_stall    pipeline freeze
//    fetch_req     IF stage read request
//    fetch_addr    IF stage byte address
//    fetch_valid   fetch_instr is valid this cycle
//    fetch_fault   fetch to a misaligned address
//    fetch_instr   fetched instruction word
//    mem_addr      byte address to the instruction memory
//    mem_we        memory write enable
//    mem_wdata     memory write data
//    mem_rdata     asynchronous memory read data

module imem_loader #(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load_start,
   input  logic [ADDR_WIDTH-2:0] load_len,
   input  logic [DATA_WIDTH-1:0] load_checksum,
   input  logic                  load_valid,
   input  logic [DATA_WIDTH-1:0] load_data,
   output logic                  load_ready,
   output logic                  load_done,
   output logic                  load_error,
   output logic                  core_stall,
   input  logic                  fetch_req,
   input  logic [ADDR_WIDTH-1:0] fetch_addr,
   output logic                  fetch_valid,
   output logic                  fetch_fault,
   output logic [DATA_WIDTH-1:0] fetch_instr,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_we,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   // Word pointer spans the memory depth; the counter needs one more bit so
   // that a full-depth length (2^(ADDR_WIDTH-2)) is representable.
   localparam int PTR_W = ADDR_WIDTH - 2;
   localparam int CNT_W = ADDR_WIDTH - 1;
   localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

`ifdef IMEM_LOAD_CHECKSUM_EN
   typedef enum logic [2:0] {
      S_BOOT_WAIT = 3'd0,
      S_LOAD      = 3'd1,
      S_CHECK     = 3'd2,
      S_RUN       = 3'd3,
      S_ERROR     = 3'd4
   } state_t;
`else
   typedef enum logic [1:0] {
      S_BOOT_WAIT = 2'd0,
      S_LOAD      = 2'd1,
      S_RUN       = 2'd2
   } state_t;
`endif

   state_t           state_q, state_d;
   logic [PTR_W-1:0] ptr_q, ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [CNT_W-1:0] len_q, len_d;
   logic             done_q, done_d;

`ifdef IMEM_LOAD_CHECKSUM_EN
   logic [DATA_WIDTH-1:0] sum_q, sum_d;
   logic [DATA_WIDTH-1:0] chk_q, chk_d;
`else
   // Checksum input has no consumer in this build.
   logic unused_checksum;
   assign unused_checksum = ^load_checksum;
`endif

   logic start_sess;   // a new session is opened this cycle
   logic load_end;     // the image is complete after this cycle

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_BOOT_WAIT;
         ptr_q   <= '0;
         count_q <= '0;
         len_q   <= '0;
         done_q  <= 1'b0;
`ifdef IMEM_LOAD_CHECKSUM_EN
         sum_q   <= '0;
         chk_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         count_q <= count_d;
         len_q   <= len_d;
         done_q  <= done_d;
`ifdef IMEM_LOAD_CHECKSUM_EN
         sum_q   <= sum_d;
         chk_q   <= chk_d;
`endif
      end
   end

   // ------------------------------------------------------------------
   // Next state and outputs
   // ------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      count_d     = count_q;
      len_d       = len_q;
      done_d      = 1'b0;
`ifdef IMEM_LOAD_CHECKSUM_EN
      sum_d       = sum_q;
      chk_d       = chk_q;
`endif
      start_sess  = 1'b0;
      load_end    = 1'b0;

      load_ready  = 1'b0;
      core_stall  = 1'b1;
      mem_we      = 1'b0;
      mem_addr    = '0;
      mem_wdata   = '0;
      fetch_valid = 1'b0;
      fetch_fault = 1'b0;
      fetch_instr = '0;

      case (state_q)
         S_BOOT_WAIT: begin
            start_sess = load_start;
         end

         S_LOAD: begin
            load_ready = 1'b1;
            mem_addr   = {ptr_q, 2'b00};
            if (load_valid) begin
               mem_we    = 1'b1;
               mem_wdata = load_data;
               ptr_d     = ptr_q + PTR_ONE;   // wraps naturally at full depth
               count_d   = count_q + CNT_ONE;
`ifdef IMEM_LOAD_CHECKSUM_EN
               sum_d     = sum_q + load_data;
`endif
               load_end  = (count_d == len_q);
            end
         end

`ifdef IMEM_LOAD_CHECKSUM_EN
         S_CHECK: begin
            if (sum_q == chk_q) begin
               state_d = S_RUN;
               done_d  = 1'b1;
            end else begin
               state_d = S_ERROR;
            end
         end

         S_ERROR: begin
            start_sess = load_start;
         end
`endif

         S_RUN: begin
            // The IF stage owns the read port; the stall only rises in the
            // cycle after a new load_start is seen.
            core_stall  = 1'b0;
            mem_addr    = fetch_addr;
            fetch_instr = mem_rdata;
            fetch_valid = fetch_req & (fetch_addr[1:0] == 2'b00);
            fetch_fault = fetch_req & (fetch_addr[1:0] != 2'b00);
            start_sess  = load_start;
         end

         default: begin
            state_d = S_BOOT_WAIT;
         end
      endcase

      if (start_sess) begin
         len_d   = load_len;
         ptr_d   = '0;
         count_d = '0;
`ifdef IMEM_LOAD_CHECKSUM_EN
         sum_d   = '0;
         chk_d   = load_checksum;
`endif
         // An empty image skips LOAD and goes straight to the end step.
         if (load_len == '0) begin
            load_end = 1'b1;
         end else begin
            state_d = S_LOAD;
         end
      end

      if (load_end) begin
`ifdef IMEM_LOAD_CHECKSUM_EN
         state_d = S_CHECK;
`else
         state_d = S_RUN;
         done_d  = 1'b1;
`endif
      end
   end

   assign load_done = done_q;

`ifdef IMEM_LOAD_CHECKSUM_EN
   assign load_error = (state_q == S_ERROR);
`else
   assign load_error = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - self-checking bench for imem_loader

module tb_imem_loader;

   localparam int AW    = 12;
   localparam int DW    = 32;
   localparam int DEPTH = 1 << (AW - 2);

   logic          clk;
   logic          rst_n;
   logic          load_start;
   logic [AW-2:0] load_len;
   logic [DW-1:0] load_checksum;
   logic          load_valid;
   logic [DW-1:0] load_data;
   logic          load_ready;
   logic          load_done;
   logic          load_error;
   logic          core_stall;
   logic          fetch_req;
   logic [AW-1:0] fetch_addr;
   logic          fetch_valid;
   logic          fetch_fault;
   logic [DW-1:0] fetch_instr;
   logic [AW-1:0] mem_addr;
   logic          mem_we;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;

   imem_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .load_start    (load_start),
      .load_len      (load_len),
      .load_checksum (load_checksum),
      .load_valid    (load_valid),
      .load_data     (load_data),
      .load_ready    (load_ready),
      .load_done     (load_done),
      .load_error    (load_error),
      .core_stall    (core_stall),
      .fetch_req     (fetch_req),
      .fetch_addr    (fetch_addr),
      .fetch_valid   (fetch_valid),
      .fetch_fault   (fetch_fault),
      .fetch_instr   (fetch_instr),
      .mem_addr      (mem_addr),
      .mem_we        (mem_we),
      .mem_wdata     (mem_wdata),
      .mem_rdata     (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instruction memory: synchronous write, asynchronous read.
   logic [DW-1:0] mem [0:DEPTH-1];
   always @(posedge clk) if (mem_we === 1'b1) mem[mem_addr[AW-1:2]] <= mem_wdata;
   assign mem_rdata = mem[mem_addr[AW-1:2]];

   int n_pass = 0;
   int n_fail = 0;
   int n_total = 0;

   logic [AW+DW-1:0] sb_q[$];
   logic [DW-1:0]    exp_mem [0:DEPTH-1];
   int               exp_ptr;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Write monitor: every write must match the next scoreboard entry.
   always @(negedge clk) begin
      if (mem_we === 1'b1) begin
         if (sb_q.size() == 0) begin
            chk("spurious_we", {63'd0, mem_we}, 64'd0);
         end else begin
            logic [AW+DW-1:0] e;
            e = sb_q.pop_front();
            chk("wr_addr", {52'd0, mem_addr}, {52'd0, e[AW+DW-1:DW]});
            chk("wr_data", {32'd0, mem_wdata}, {32'd0, e[DW-1:0]});
         end
         chk("we_vs_fetch", {63'd0, fetch_valid}, 64'd0);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic start_load(input int len, input logic [DW-1:0] cks);
      load_start    = 1'b1;
      load_len      = (AW-1)'(len);
      load_checksum = cks;
      exp_ptr       = 0;
      step();
      load_start    = 1'b0;
   endtask

   task automatic send(input logic [DW-1:0] d, input logic v);
      load_valid = v;
      load_data  = d;
      if (v) begin
         logic [AW-1:0] a;
         a = AW'(exp_ptr * 4);
         sb_q.push_back({a, d});
         exp_mem[exp_ptr] = d;
         exp_ptr = (exp_ptr + 1) % DEPTH;
      end
      #1;
      chk("ld_ready", {63'd0, load_ready}, 64'd1);
      chk("ld_we", {63'd0, mem_we}, {63'd0, v});
      chk("ld_stall", {63'd0, core_stall}, 64'd1);
      chk("ld_done_low", {63'd0, load_done}, 64'd0);
      step();
      load_valid = 1'b0;
   endtask

   // Called one cycle after the final accepting edge (or the load_start edge
   // of an empty image).
   task automatic finish_ok();
`ifdef IMEM_LOAD_CHECKSUM_EN
      chk("chk_stall", {63'd0, core_stall}, 64'd1);
      chk("chk_done", {63'd0, load_done}, 64'd0);
      chk("chk_ready", {63'd0, load_ready}, 64'd0);
      step();
`endif
      chk("run_done", {63'd0, load_done}, 64'd1);
      chk("run_stall", {63'd0, core_stall}, 64'd0);
      chk("run_ready", {63'd0, load_ready}, 64'd0);
      chk("run_error", {63'd0, load_error}, 64'd0);
      step();
      chk("done_pulse", {63'd0, load_done}, 64'd0);
   endtask

   task automatic do_fetch(input logic [AW-1:0] a, input logic exp_v, input logic exp_f);
      fetch_req  = 1'b1;
      fetch_addr = a;
      #1;
      chk("f_valid", {63'd0, fetch_valid}, {63'd0, exp_v});
      chk("f_fault", {63'd0, fetch_fault}, {63'd0, exp_f});
      if (exp_v) chk("f_instr", {32'd0, fetch_instr}, {32'd0, exp_mem[a[AW-1:2]]});
      fetch_req = 1'b0;
   endtask

   logic [DW-1:0] img [0:3];
   logic [DW-1:0] sum;

   initial begin
      img[0] = 32'h00000013;
      img[1] = 32'h00100093;
      img[2] = 32'h00200113;
      img[3] = 32'h002081B3;
      rst_n = 1'b0; load_start = 1'b0; load_len = '0; load_checksum = '0;
      load_valid = 1'b0; load_data = '0; fetch_req = 1'b0; fetch_addr = '0;
      exp_ptr = 0;
      step();
      step();
      chk("rst_stall", {63'd0, core_stall}, 64'd1);
      chk("rst_ready", {63'd0, load_ready}, 64'd0);
      chk("rst_done", {63'd0, load_done}, 64'd0);
      chk("rst_error", {63'd0, load_error}, 64'd0);
      chk("rst_we", {63'd0, mem_we}, 64'd0);
      chk("rst_addr", {52'd0, mem_addr}, 64'd0);
      chk("rst_wdata", {32'd0, mem_wdata}, 64'd0);
      chk("rst_fvalid", {63'd0, fetch_valid}, 64'd0);
      chk("rst_ffault", {63'd0, fetch_fault}, 64'd0);
      rst_n = 1'b1;

      // Idle in BOOT_WAIT with fetch requests present.
      fetch_req = 1'b1;
      fetch_addr = 12'h008;
      for (int i = 0; i < 10; i++) begin
         step();
         chk("idle_stall", {63'd0, core_stall}, 64'd1);
         chk("idle_ready", {63'd0, load_ready}, 64'd0);
         chk("idle_fvalid", {63'd0, fetch_valid}, 64'd0);
         chk("idle_instr", {32'd0, fetch_instr}, 64'd0);
      end
      fetch_req = 1'b0;

      // Back-to-back 4-word load.
      sum = '0;
      for (int i = 0; i < 4; i++) sum += img[i];
      start_load(4, sum);
      for (int i = 0; i < 4; i++) send(img[i], 1'b1);
      finish_ok();
      do_fetch(12'h008, 1'b1, 1'b0);
      chk("f_instr_abs", {32'd0, fetch_instr}, 64'h00200113);
      do_fetch(12'h000, 1'b1, 1'b0);
      do_fetch(12'h006, 1'b0, 1'b1);
      do_fetch(12'h00C, 1'b1, 1'b0);

      // Reload from RUN with load_valid toggling; new data proves rewrite.
      sum = '0;
      for (int i = 0; i < 4; i++) sum += img[i] ^ 32'h11110000;
      load_start = 1'b1; load_len = 11'd4; load_checksum = sum; exp_ptr = 0;
      #1;
      chk("rl_stall_same_cycle", {63'd0, core_stall}, 64'd0);
      step();
      load_start = 1'b0;
      chk("rl_stall_next", {63'd0, core_stall}, 64'd1);
      for (int i = 0; i < 7; i++) begin
         if (i % 2 == 0) send(img[i/2] ^ 32'h11110000, 1'b1);
         else send(32'hDEADBEEF, 1'b0);
      end
      finish_ok();
      do_fetch(12'h004, 1'b1, 1'b0);
      do_fetch(12'h00C, 1'b1, 1'b0);

      // Empty image.
      start_load(0, 32'd0);
      finish_ok();

      // Two-word image, correct then wrong checksum.
      start_load(2, 32'h3);
      send(32'h1, 1'b1);
      send(32'h2, 1'b1);
      finish_ok();
      start_load(2, 32'h4);
      send(32'h1, 1'b1);
      send(32'h2, 1'b1);
`ifdef IMEM_LOAD_CHECKSUM_EN
      chk("bad_chk_stall", {63'd0, core_stall}, 64'd1);
      step();
      chk("err_error", {63'd0, load_error}, 64'd1);
      chk("err_stall", {63'd0, core_stall}, 64'd1);
      chk("err_done", {63'd0, load_done}, 64'd0);
      step();
      chk("err_held", {63'd0, load_error}, 64'd1);
      start_load(1, 32'h5);
      chk("err_cleared", {63'd0, load_error}, 64'd0);
      send(32'h5, 1'b1);
      finish_ok();
`else
      finish_ok();
`endif
      do_fetch(12'h000, 1'b1, 1'b0);

      // Reset in the middle of a load; written words survive.
      start_load(4, 32'hA0 + 32'hA1 + 32'hA2 + 32'hA3);
      send(32'hA0, 1'b1);
      send(32'hA1, 1'b1);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      chk("mr_stall", {63'd0, core_stall}, 64'd1);
      chk("mr_ready", {63'd0, load_ready}, 64'd0);
      step();
      chk("mr_boot_ready", {63'd0, load_ready}, 64'd0);
      start_load(1, 32'hB0);
      send(32'hB0, 1'b1);
      finish_ok();
      do_fetch(12'h000, 1'b1, 1'b0);
      do_fetch(12'h004, 1'b1, 1'b0);
      chk("mr_kept", {32'd0, fetch_instr}, 64'hA1);

      // Full-depth image: pointer wraps after the last write, no extra write.
      sum = '0;
      for (int i = 0; i < DEPTH; i++) sum += 32'(i) * 32'h9E3779B1;
      start_load(DEPTH, sum);
      for (int i = 0; i < DEPTH; i++) send(32'(i) * 32'h9E3779B1, 1'b1);
      finish_ok();
      do_fetch(12'hFFC, 1'b1, 1'b0);
      do_fetch(12'h000, 1'b1, 1'b0);
      do_fetch(12'h801, 1'b0, 1'b1);
      step();
      step();
      chk("sb_empty", 64'(sb_q.size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time loader and access controller for the instruction memory. After reset it holds the pipeline stalled and streams a program image word by word into the instruction memory's write port. It then hands the memory read port to the IF stage and releases the stall. A later load request stalls the core again and reloads the image in place.

## Interface
Parameters:
- ADDR_WIDTH, 12, byte-address width of instruction memory (2^(ADDR_WIDTH-2) words)
- DATA_WIDTH, 32, instruction/word width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- load_start  in  1  request a load session; sampled in BOOT_WAIT, RUN, ERROR
- load_len  in  ADDR_WIDTH-1  word count of image, 0..2^(ADDR_WIDTH-2); sampled with load_start
- load_checksum  in  DATA_WIDTH  expected mod-2^32 sum of image words; sampled with load_start
- load_valid  in  1  load_data holds a valid word
- load_data  in  DATA_WIDTH  image word
- load_ready  out  1  loader accepts a word this cycle
- load_done  out  1  one-cycle pulse: load completed successfully
- load_error  out  1  checksum mismatch; held until next load_start
- core_stall  out  1  pipeline freeze (PC and IF/ID hold)
- fetch_req  in  1  IF stage read request
- fetch_addr  in  ADDR_WIDTH  byte address (PC)
- fetch_valid  out  1  fetch_instr valid this cycle
- fetch_fault  out  1  fetch to misaligned address
- fetch_instr  out  DATA_WIDTH  instruction word
- mem_addr  out  ADDR_WIDTH  byte address to memory
- mem_we  out  1  memory write enable (write on clk edge)
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_rdata  in  DATA_WIDTH  asynchronous memory read data

## Operation
- States: BOOT_WAIT, LOAD, CHECK (macro only), RUN, ERROR.
- Reset (rst_n=0 at edge): state BOOT_WAIT, word pointer 0, count 0, sum 0. core_stall=1. load_ready, load_done, load_error, mem_we, fetch_valid and fetch_fault all 0. mem_addr=0, mem_wdata=0. Reset mid-LOAD abandons the session; already-written words are not cleared.
- BOOT_WAIT: on load_start, latch load_len and load_checksum, clear pointer and sum, go to LOAD. load_len=0 bypasses LOAD and goes straight to the end-of-load step (CHECK or RUN).
- LOAD: load_ready=1 and core_stall=1. A word transfers on any cycle with load_valid&load_ready. In that cycle: mem_we=1, mem_addr={ptr,2'b00}, mem_wdata=load_data. After the write, ptr increments (wraps at depth), count increments, and sum += load_data mod 2^32. When the transfer makes count equal load_len, go to CHECK or RUN. load_start is ignored in LOAD.
- RUN: core_stall=0, load_ready=0. Fetch path is combinational: mem_addr=fetch_addr, fetch_instr=mem_rdata. fetch_valid=fetch_req&(fetch_addr[1:0]==0). fetch_fault=fetch_req&(fetch_addr[1:0]!=0), with fetch_valid=0. load_start in RUN latches and goes to LOAD with stall asserted from the next cycle.
- Outside RUN: fetch_valid=0, fetch_fault=0, fetch_instr=0, mem_rdata ignored.
- ERROR: core_stall=1, load_error=1. load_start clears load_error and restarts as in BOOT_WAIT.
- mem_we is 1 only in LOAD on an accepted transfer. No write and fetch ever share a cycle.

## Timing
- Word accepted at edge N is written at edge N. It is readable via mem_rdata in RUN from cycle N+1.
- Without macro: last word accepted at edge N means state is RUN in cycle N+1 with load_done=1 and core_stall=0 that cycle. load_done is low otherwise.
- With macro: last word at edge N gives CHECK in cycle N+1 (stall=1). Cycle N+2 is RUN with load_done=1, or ERROR with load_error=1.
- load_start to first load_ready is one cycle (LOAD entered next cycle).
- Throughput: one word per cycle with load_valid held high.
- load_len=0: load_start at edge N gives RUN/load_done in cycle N+1 (no macro) or CHECK then cycle N+2 (macro; sum 0 compared with checksum).
- Full-depth load (load_len=2^(ADDR_WIDTH-2)): pointer wraps to 0 after the final write; no extra write occurs.

## Configuration
- IMEM_LOAD_CHECKSUM_EN defined: sum accumulator, CHECK state and ERROR state are present. In CHECK, sum==latched checksum leads to RUN, otherwise ERROR.
- Undefined: no accumulator, CHECK or ERROR. load_checksum is ignored, load_error is tied 0, and LOAD goes directly to RUN.

## Test plan
- Reset then idle 10 cycles -> core_stall=1, load_ready=0, fetch_valid=0 throughout even with fetch_req=1.
- load_start, load_len=4, words 0x00000013,0x00100093,0x00200113,0x002081B3 back-to-back -> mem_we on 4 consecutive cycles at byte addresses 0,4,8,12. load_done pulses once, core_stall drops. fetch_addr=8 returns 0x00200113 with fetch_valid=1.
- Same load with load_valid toggling 1,0,1,0 -> writes occur only on valid cycles, address sequence unchanged, load_done timing follows the last accepted word.
- In RUN, fetch_addr=0x006 with fetch_req=1 -> fetch_fault=1, fetch_valid=0.
- Macro on: load 2 words 0x1,0x2 with checksum 0x3 -> RUN with done. Checksum 0x4 -> ERROR, load_error=1, stall=1. Then load_start -> error clears, LOAD.
- rst_n low for one cycle after 2 of 4 words -> BOOT_WAIT, stall=1. A new load_start with len 1 writes address 0.
